// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I opcodes, funct3
// width/sign encodings for loads and stores, the LSU state type and the
// access-legality helper used when an access is accepted.
package load_store_unit_pkg;

  // Base RV32I opcodes
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

  // Load funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } lsu_state_t;

  // 1 when funct3 is a legal width for the access direction and the
  // address is naturally aligned for that width.
  function automatic logic lsu_access_legal(input logic       st,
                                            input logic [2:0] f3,
                                            input logic [1:0] lo);
    logic ok;
    ok = 1'b0;
    // SB/SH/SW share encodings with LB/LH/LW, so only load names appear here.
    case (f3)
      F3_LB:   ok = 1'b1;
      F3_LH:   ok = ~lo[0];
      F3_LW:   ok = (lo == 2'b00);
      F3_LBU:  ok = ~st;
      F3_LHU:  ok = ~st & ~lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory request/acknowledge port.
//   master (LSU side):    drives mem_req, mem_we, mem_addr, mem_wmask, mem_wdata
//                         samples mem_ack, mem_rdata
//   slave  (memory side): the reverse
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wmask, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wmask, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/load_store_unit_load_align.sv
// Combinational load aligner: picks the addressed byte/halfword out of the
// read word and sign- or zero-extends it according to funct3.
//   rdata     in  32  word returned by memory
//   addr_lo   in  2   low address bits selecting the lane
//   funct3    in  3   RV32I load width/sign encoding
//   load_word out 32  aligned, extended result
module lsu_load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] load_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = '0;
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    load_word = '0;
    case (funct3)
      F3_LB:   load_word = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  load_word = {24'd0, byte_sel};
      F3_LH:   load_word = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  load_word = {16'd0, half_sel};
      F3_LW:   load_word = rdata;
      default: load_word = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: takes the ALU effective address for a load or store,
// runs one req/ack transaction on the data-memory port and returns an aligned,
// extended load result. Misaligned or illegal accesses complete without ever
// raising mem_req; a memory that never acks is aborted after TIMEOUT_CYCLES.
//   clk, reset        single clock, synchronous active-high reset
//   start             begin access (sampled only when idle)
//   is_store, funct3  direction and width/sign select
//   addr, store_data  effective address and rs2 value
//   busy, done        busy in ACCESS/DONE; done pulses one cycle with results
//   load_data, misaligned, bus_error   results, valid with done
//   mem               data-memory port (master side)
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      is_store,
  input  logic [2:0]                funct3,
  input  logic [31:0]               addr,
  input  logic [31:0]               store_data,
  output logic                      busy,
  output logic                      done,
  output logic [31:0]               load_data,
  output logic                      misaligned,
  output logic                      bus_error,
  load_store_unit_if.master         mem
);

  // Counter holds 0..TIMEOUT_CYCLES-1 ack-less cycles already seen.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              is_store_q, is_store_d;
  logic [31:0]       store_data_q, store_data_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              misaligned_q, misaligned_d;
  logic              bus_error_q, bus_error_d;

  logic [31:0]       aligned_word;
  logic [3:0]        store_mask;
  logic [31:0]       store_word;
  logic              in_access;

  lsu_load_align u_load_align (
    .rdata     (mem.mem_rdata),
    .addr_lo   (addr_q[1:0]),
    .funct3    (funct3_q),
    .load_word (aligned_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      funct3_q     <= '0;
      is_store_q   <= 1'b0;
      store_data_q <= '0;
      load_data_q  <= '0;
      misaligned_q <= 1'b0;
      bus_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      funct3_q     <= funct3_d;
      is_store_q   <= is_store_d;
      store_data_q <= store_data_d;
      load_data_q  <= load_data_d;
      misaligned_q <= misaligned_d;
      bus_error_q  <= bus_error_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    funct3_d     = funct3_q;
    is_store_d   = is_store_q;
    store_data_d = store_data_q;
    load_data_d  = load_data_q;
    misaligned_d = misaligned_q;
    bus_error_d  = bus_error_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d       = addr;
          funct3_d     = funct3;
          is_store_d   = is_store;
          store_data_d = store_data;
          cnt_d        = '0;
          if (lsu_access_legal(is_store, funct3, addr[1:0])) begin
            state_d = ACCESS;
          end else begin
            state_d      = DONE;
            misaligned_d = 1'b1;
            bus_error_d  = 1'b0;
            load_data_d  = '0;
          end
        end
      end

      ACCESS: begin
        // Ack takes priority over expiry in the same cycle.
        if (mem.mem_ack) begin
          state_d      = DONE;
          load_data_d  = is_store_q ? '0 : aligned_word;
          misaligned_d = 1'b0;
          bus_error_d  = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = DONE;
          load_data_d  = '0;
          misaligned_d = 1'b0;
          bus_error_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        state_d      = IDLE;
        load_data_d  = '0;
        misaligned_d = 1'b0;
        bus_error_d  = 1'b0;
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    store_mask = 4'b1111;
    store_word = store_data_q;
    case (funct3_q[1:0])
      2'b00: begin
        store_mask = 4'b0001 << addr_q[1:0];
        store_word = {4{store_data_q[7:0]}};
      end
      2'b01: begin
        store_mask = 4'b0011 << {addr_q[1], 1'b0};
        store_word = {2{store_data_q[15:0]}};
      end
      default: begin
        store_mask = 4'b1111;
        store_word = store_data_q;
      end
    endcase
  end

  // Bus outputs are forced to zero outside ACCESS so idle/reset looks quiet.
  always_comb begin
    in_access     = (state_q == ACCESS);
    mem.mem_req   = in_access;
    mem.mem_we    = in_access & is_store_q;
    mem.mem_addr  = in_access ? {addr_q[31:2], 2'b00} : '0;
    mem.mem_wmask = (in_access && is_store_q) ? store_mask : '0;
    mem.mem_wdata = (in_access && is_store_q) ? store_word : '0;
  end

  assign busy       = (state_q == ACCESS) || (state_q == DONE);
  assign done       = (state_q == DONE);
  assign load_data  = load_data_q;
  assign misaligned = misaligned_q;
  assign bus_error  = bus_error_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        misaligned;
  logic        bus_error;

  load_store_unit_if mem_if();

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .load_data  (load_data),
    .misaligned (misaligned),
    .bus_error  (bus_error),
    .mem        (mem_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ld;
    logic        mis;
    logic        berr;
    int unsigned lat;
  } resp_t;

  typedef struct {
    logic [31:0] a;
    logic        we;
    logic [3:0]  mask;
    logic [31:0] wd;
  } req_t;

  resp_t resp_q[$];
  req_t  req_q[$];

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned start_cyc = 0;
  int unsigned req_cycles = 0;

  // memory responder configuration
  int unsigned ack_at = 1;
  int unsigned req_run = 0;
  logic        stray_ack = 1'b0;
  logic [31:0] rdata_cfg = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: acks on the ack_at-th consecutive request cycle (0 = never).
  always @(negedge clk) begin
    if (mem_if.mem_req) begin
      req_run++;
      mem_if.mem_ack = (ack_at != 0) && (req_run == ack_at);
    end else begin
      req_run = 0;
      mem_if.mem_ack = stray_ack;
    end
    mem_if.mem_rdata = rdata_cfg;
  end

  // Monitor: compares bus requests and done responses against the scoreboard.
  logic  prev_done = 1'b0;
  logic  prev_req  = 1'b0;
  req_t  cur_req;
  resp_t cur_resp;

  always @(negedge clk) begin
    if (mem_if.mem_req === 1'b1) begin
      req_cycles++;
      if (!prev_req) begin
        if (req_q.size() == 0) begin
          check("unexpected_mem_req", 32'(mem_if.mem_req), 32'd0);
        end else begin
          cur_req = req_q.pop_front();
          check("mem_addr", mem_if.mem_addr, cur_req.a);
          check("mem_we", 32'(mem_if.mem_we), 32'(cur_req.we));
          if (cur_req.we) begin
            check("mem_wmask", 32'(mem_if.mem_wmask), 32'(cur_req.mask));
            check("mem_wdata", mem_if.mem_wdata, cur_req.wd);
          end
        end
      end else begin
        check("mem_addr_stable", mem_if.mem_addr, cur_req.a);
        check("mem_we_stable", 32'(mem_if.mem_we), 32'(cur_req.we));
      end
    end
    if (done === 1'b1) begin
      check("done_single_cycle", 32'(prev_done), 32'd0);
      check("busy_in_done", 32'(busy), 32'd1);
      if (resp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        cur_resp = resp_q.pop_front();
        check("load_data", load_data, cur_resp.ld);
        check("misaligned", 32'(misaligned), 32'(cur_resp.mis));
        check("bus_error", 32'(bus_error), 32'(cur_resp.berr));
        check("latency", 32'(cyc - start_cyc), 32'(cur_resp.lat));
      end
    end
    prev_done = done;
    prev_req  = mem_if.mem_req;
  end

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd);
    @(negedge clk);
    is_store   = st;
    funct3     = f3;
    addr       = a;
    store_data = sd;
    start      = 1'b1;
    start_cyc  = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int unsigned n;
    n = 0;
    while (resp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (resp_q.size() != 0) begin
      check("done_timeout", 32'(resp_q.size()), 32'd0);
      resp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input string name, input logic st, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                     input int unsigned ack, input logic [31:0] exp_ld, input logic exp_mis,
                     input logic exp_berr, input int unsigned exp_lat,
                     input logic [3:0] exp_mask, input logic [31:0] exp_wd,
                     input int unsigned exp_req_cycles);
    int unsigned rc0;
    rdata_cfg = rd;
    ack_at    = ack;
    resp_q.push_back(resp_t'{exp_ld, exp_mis, exp_berr, exp_lat});
    if (exp_req_cycles != 0)
      req_q.push_back(req_t'{{a[31:2], 2'b00}, st, exp_mask, exp_wd});
    rc0 = req_cycles;
    issue(st, f3, a, sd);
    wait_done();
    check({name, "_req_cycles"}, 32'(req_cycles - rc0), 32'(exp_req_cycles));
  endtask

  task automatic check_quiet(input string name);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_load_data"}, load_data, 32'd0);
    check({name, "_flags"}, {30'd0, misaligned, bus_error}, 32'd0);
    check({name, "_mem_req"}, 32'(mem_if.mem_req), 32'd0);
    check({name, "_mem_bus"}, {31'd0, mem_if.mem_we} | mem_if.mem_addr, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int unsigned rc0;
    reset = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = '0;
    addr = '0; store_data = '0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    reset = 1'b0;
    @(negedge clk);

    //  name      st  f3      addr          sd            rdata         ack  exp_ld        mis berr lat mask     wdata        reqcyc
    run("lw",     0, F3_LW,  32'h100, 32'h0,         32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 0, 2, 4'b0000, 32'h0,        1);
    run("lb",     0, F3_LB,  32'h103, 32'h0,         32'h80112233, 1, 32'hFFFFFF80, 0, 0, 2, 4'b0000, 32'h0,        1);
    run("lbu",    0, F3_LBU, 32'h103, 32'h0,         32'h80112233, 1, 32'h00000080, 0, 0, 2, 4'b0000, 32'h0,        1);
    run("lh",     0, F3_LH,  32'h102, 32'h0,         32'h80112233, 1, 32'hFFFF8011, 0, 0, 2, 4'b0000, 32'h0,        1);
    run("lhu",    0, F3_LHU, 32'h102, 32'h0,         32'h80112233, 1, 32'h00008011, 0, 0, 2, 4'b0000, 32'h0,        1);
    run("lb1",    0, F3_LB,  32'h101, 32'h0,         32'h80112233, 1, 32'h00000022, 0, 0, 2, 4'b0000, 32'h0,        1);
    run("lh0",    0, F3_LH,  32'h100, 32'h0,         32'h1234F00D, 2, 32'hFFFFF00D, 0, 0, 3, 4'b0000, 32'h0,        2);
    run("sb",     1, F3_SB,  32'h201, 32'h000000AB,  32'hFFFFFFFF, 1, 32'h0,        0, 0, 2, 4'b0010, 32'hABABABAB, 1);
    run("sh",     1, F3_SH,  32'h202, 32'h1234CDEF,  32'hFFFFFFFF, 1, 32'h0,        0, 0, 2, 4'b1100, 32'hCDEFCDEF, 1);
    run("sb0",    1, F3_SB,  32'h200, 32'h0000005A,  32'hFFFFFFFF, 2, 32'h0,        0, 0, 3, 4'b0001, 32'h5A5A5A5A, 2);
    run("sw",     1, F3_SW,  32'h204, 32'hCAFEF00D,  32'hFFFFFFFF, 3, 32'h0,        0, 0, 4, 4'b1111, 32'hCAFEF00D, 3);
    run("mis_lw", 0, F3_LW,  32'h102, 32'h0,         32'hFFFFFFFF, 1, 32'h0,        1, 0, 1, 4'b0000, 32'h0,        0);
    run("ill_l3", 0, 3'd3,   32'h100, 32'h0,         32'hFFFFFFFF, 1, 32'h0,        1, 0, 1, 4'b0000, 32'h0,        0);
    run("mis_lh", 0, F3_LH,  32'h101, 32'h0,         32'hFFFFFFFF, 1, 32'h0,        1, 0, 1, 4'b0000, 32'h0,        0);
    run("mis_sh", 1, F3_SH,  32'h203, 32'h0,         32'hFFFFFFFF, 1, 32'h0,        1, 0, 1, 4'b0000, 32'h0,        0);
    run("mis_sw", 1, F3_SW,  32'h206, 32'h0,         32'hFFFFFFFF, 1, 32'h0,        1, 0, 1, 4'b0000, 32'h0,        0);
    run("ill_s4", 1, 3'd4,   32'h200, 32'h0,         32'hFFFFFFFF, 1, 32'h0,        1, 0, 1, 4'b0000, 32'h0,        0);
    run("tmo",    0, F3_LW,  32'h300, 32'h0,         32'h0BADF00D, 0, 32'h0,        0, 1, 5, 4'b0000, 32'h0,        4);
    run("ack4",   0, F3_LW,  32'h300, 32'h0,         32'h0BADF00D, 4, 32'h0BADF00D, 0, 0, 5, 4'b0000, 32'h0,        4);

    // start pulsed while ACCESS is in progress must be ignored
    rdata_cfg = 32'h11223344;
    ack_at    = 3;
    resp_q.push_back(resp_t'{32'h11223344, 1'b0, 1'b0, 4});
    req_q.push_back(req_t'{32'h400, 1'b0, 4'b0000, 32'h0});
    rc0 = req_cycles;
    issue(1'b0, F3_LW, 32'h400, 32'h0);
    addr = 32'h500; is_store = 1'b1; funct3 = F3_SW; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    check("busy_start_req_cycles", 32'(req_cycles - rc0), 32'd3);

    // reset in the middle of ACCESS
    ack_at = 0;
    req_q.push_back(req_t'{32'h600, 1'b0, 4'b0000, 32'h0});
    issue(1'b0, F3_LW, 32'h600, 32'h0);
    @(negedge clk);
    check("pre_reset_mem_req", 32'(mem_if.mem_req), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_quiet("mid_reset");
    reset = 1'b0;
    stray_ack = 1'b1;
    repeat (3) @(negedge clk);
    check("stray_ack_busy", 32'(busy), 32'd0);
    stray_ack = 1'b0;
    @(negedge clk);
    run("post_reset", 0, F3_LW, 32'h700, 32'h0, 32'h76543210, 1, 32'h76543210, 0, 0, 2, 4'b0000, 32'h0, 1);

    repeat (3) @(negedge clk);
    check("resp_queue_empty", 32'(resp_q.size()), 32'd0);
    check("req_queue_empty", 32'(req_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
